// File: rtl/gb80_pkg.sv
// Shared GB80 datapath constants: 8-bit register map, register-pair map
// and the architectural reset values of SP and PC.
package gb80_pkg;

  typedef enum logic [2:0] {
    REG_B    = 3'd0,
    REG_C    = 3'd1,
    REG_D    = 3'd2,
    REG_E    = 3'd3,
    REG_H    = 3'd4,
    REG_L    = 3'd5,
    REG_NONE = 3'd6,
    REG_A    = 3'd7
  } reg_idx_e;

  typedef enum logic [2:0] {
    PAIR_BC = 3'd0,
    PAIR_DE = 3'd1,
    PAIR_HL = 3'd2,
    PAIR_PC = 3'd3,
    PAIR_SP = 3'd4
  } pair_idx_e;

  localparam logic [15:0] SP_RESET_DEFAULT = 16'hFFFE;
  localparam logic [15:0] PC_RESET_DEFAULT = 16'h0000;

endpackage

// File: rtl/gb80_addr_latch_inc.sv
// Memory address latch and pair pointer: holds the last selected pair value
// on the address bus and produces the post-fetch +1 write-back.
module gb80_addr_latch_inc
  import gb80_pkg::*;
#(
  parameter int               ADDR_LENGTH = 3,
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] LATCH_RESET = PC_RESET_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   addr_rd,
  input  logic                   addr_wr,
  input  logic [ADDR_LENGTH-1:0] sel,
  input  logic [WIDTH-1:0]       pair_value,
  output logic [WIDTH-1:0]       addr_bus,
  output logic                   wb_en,
  output logic [ADDR_LENGTH-1:0] wb_sel,
  output logic [WIDTH-1:0]       wb_value
);

  logic [WIDTH-1:0]       addr_latch;
  logic [ADDR_LENGTH-1:0] ptr;

  // The increment always works from the values latched by an earlier
  // addr_rd, so a simultaneous addr_rd only affects the following cycle.
  assign addr_bus = addr_rd ? pair_value : addr_latch;
  assign wb_en    = addr_wr;
  assign wb_sel   = ptr;
  assign wb_value = addr_latch + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_latch <= LATCH_RESET;
      ptr        <= ADDR_LENGTH'(PAIR_PC);
    end else if (addr_rd) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      addr_latch <= pair_value;
      ptr        <= sel;
    end
  end

endmodule

// File: rtl/gb80_register_file.sv
// GB80 register file: B,C,D,E,H,L,A plus SP/PC, 8-bit data bus access,
// pair loads, and the address bus with post-fetch pair increment.
module gb80_register_file
  import gb80_pkg::*;
#(
  parameter int                      ADDR_LENGTH = 3,
  parameter int                      DATA_WIDTH  = 8,
  parameter logic [2*DATA_WIDTH-1:0] SP_RESET    = SP_RESET_DEFAULT,
  parameter logic [2*DATA_WIDTH-1:0] PC_RESET    = PC_RESET_DEFAULT
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [ADDR_LENGTH-1:0]  i_addr,
  input  logic                    i_wr,
  input  logic                    i_rd,
  input  logic                    i_addr_rd,
  input  logic                    i_addr_wr,
  input  logic                    i_pair_ld,
  input  logic [2*DATA_WIDTH-1:0] i_pair_data,
  input  logic [DATA_WIDTH-1:0]   i_data,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_data_oe,
  output logic [2*DATA_WIDTH-1:0] o_addr_bus
);

  localparam int PW    = 2 * DATA_WIDTH;
  localparam int NREGS = 2 ** ADDR_LENGTH;

  // Slot REG_NONE exists in the array but is never written.
  logic [DATA_WIDTH-1:0]  regs   [NREGS];
  logic [DATA_WIDTH-1:0]  regs_n [NREGS];
  logic [PW-1:0]          pc, sp, pc_n, sp_n;
  logic [PW-1:0]          pair_rd;
  logic                   wb_en;
  logic [ADDR_LENGTH-1:0] wb_sel;
  logic [PW-1:0]          wb_value;
  logic                   ld_en;
  logic [ADDR_LENGTH-1:0] ld_sel;
  logic [PW-1:0]          ld_val;

  always_comb begin
    pair_rd = '0;
    case (i_addr)
      PAIR_BC: pair_rd = {regs[REG_B], regs[REG_C]};
      PAIR_DE: pair_rd = {regs[REG_D], regs[REG_E]};
      PAIR_HL: pair_rd = {regs[REG_H], regs[REG_L]};
      PAIR_PC: pair_rd = pc;
      PAIR_SP: pair_rd = sp;
      default: pair_rd = '0;
    endcase
  end

  gb80_addr_latch_inc #(
    .ADDR_LENGTH (ADDR_LENGTH),
    .WIDTH       (PW),
    .LATCH_RESET (PC_RESET)
  ) u_addr_latch_inc (
    .clk        (i_clk),
    .reset      (i_reset),
    .addr_rd    (i_addr_rd),
    .addr_wr    (i_addr_wr),
    .sel        (i_addr),
    .pair_value (pair_rd),
    .addr_bus   (o_addr_bus),
    .wb_en      (wb_en),
    .wb_sel     (wb_sel),
    .wb_value   (wb_value)
  );

  // Writers are applied lowest priority first (byte write, pair load,
  // increment), so a later writer overrides an earlier one per byte.
  always_comb begin
    // NOTE: every combinational output is given a default up front so no
    // path leaves it unassigned and no latch is inferred.
    regs_n = regs;
    pc_n   = pc;
    sp_n   = sp;
    ld_en  = 1'b0;
    ld_sel = '0;
    ld_val = '0;
    if (i_wr && i_addr != REG_NONE) regs_n[i_addr] = i_data;
    for (int k = 0; k < 2; k++) begin
      ld_en  = (k == 0) ? i_pair_ld   : wb_en;
      ld_sel = (k == 0) ? i_addr      : wb_sel;
      ld_val = (k == 0) ? i_pair_data : wb_value;
      if (ld_en) begin
        case (ld_sel)
          PAIR_BC: {regs_n[REG_B], regs_n[REG_C]} = ld_val;
          PAIR_DE: {regs_n[REG_D], regs_n[REG_E]} = ld_val;
          PAIR_HL: {regs_n[REG_H], regs_n[REG_L]} = ld_val;
          PAIR_PC: pc_n = ld_val;
          PAIR_SP: sp_n = ld_val;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      // NOTE: this small array is architectural state and is reset in full;
      // large storage memories would normally be left unreset.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      pc <= PC_RESET;
      sp <= SP_RESET;
    end else begin
      regs <= regs_n;
      pc   <= pc_n;
      sp   <= sp_n;
    end
  end

  always_comb begin
    o_data = '0;
    if (i_rd && i_addr != REG_NONE) o_data = regs[i_addr];
  end

  assign o_data_oe = i_rd;

endmodule

// File: tb/tb_gb80_register_file.sv
// Self-checking bench for gb80_register_file: directed scenarios plus random
// strobes compared against a pair-oriented behavioural model.
module tb_gb80_register_file;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [2:0]  i_addr = '0;
  logic        i_wr = 1'b0, i_rd = 1'b0, i_addr_rd = 1'b0, i_addr_wr = 1'b0, i_pair_ld = 1'b0;
  logic [15:0] i_pair_data = '0;
  logic [7:0]  i_data = '0;
  logic [7:0]  o_data;
  logic        o_data_oe;
  logic [15:0] o_addr_bus;

  int checks = 0;
  int errors = 0;

  gb80_register_file dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_addr      (i_addr),
    .i_wr        (i_wr),
    .i_rd        (i_rd),
    .i_addr_rd   (i_addr_rd),
    .i_addr_wr   (i_addr_wr),
    .i_pair_ld   (i_pair_ld),
    .i_pair_data (i_pair_data),
    .i_data      (i_data),
    .o_data      (o_data),
    .o_data_oe   (o_data_oe),
    .o_addr_bus  (o_addr_bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pairs as 16-bit words (BC, DE, HL, PC, SP) plus A.
  logic [15:0] m_pair [5];
  logic [7:0]  m_a;
  logic [15:0] m_latch;
  logic [2:0]  m_ptr;
  bit          m_valid = 1'b0;

  function automatic logic [15:0] m_pairv(input logic [2:0] p);
    return (p < 3'd5) ? m_pair[p] : 16'h0000;
  endfunction

  function automatic logic [7:0] m_byte(input logic [2:0] r);
    logic [15:0] w;
    if (r == 3'd7) return m_a;
    if (r == 3'd6) return 8'h00;
    w = m_pair[r >> 1];
    return r[0] ? w[7:0] : w[15:8];
  endfunction

  task automatic model_update();
    logic [15:0] old_latch, rd_val, w;
    logic [2:0]  old_ptr;
    if (i_reset) begin
      for (int p = 0; p < 3; p++) m_pair[p] = 16'h0000;
      m_pair[3] = 16'h0000;
      m_pair[4] = 16'hFFFE;
      m_a       = 8'h00;
      m_latch   = 16'h0000;
      m_ptr     = 3'd3;
      m_valid   = 1'b1;
      return;
    end
    old_latch = m_latch;
    old_ptr   = m_ptr;
    rd_val    = m_pairv(i_addr);
    if (i_wr) begin
      if (i_addr == 3'd7) m_a = i_data;
      else if (i_addr != 3'd6) begin
        w = m_pair[i_addr >> 1];
        if (i_addr[0]) w[7:0] = i_data; else w[15:8] = i_data;
        m_pair[i_addr >> 1] = w;
      end
    end
    if (i_pair_ld && i_addr < 3'd5) m_pair[i_addr] = i_pair_data;
    if (i_addr_wr && old_ptr < 3'd5) m_pair[old_ptr] = old_latch + 16'd1;
    if (i_addr_rd) begin
      m_latch = rd_val;
      m_ptr   = i_addr;
    end
  endtask

  logic [7:0]  obs_data;
  logic        obs_oe;
  logic [15:0] obs_bus;

  // Called at a negedge: drive, sample mid-low-phase, clock, update model.
  task automatic step(input logic rst, input logic rd, input logic wr, input logic ard,
                      input logic awr, input logic pld, input logic [2:0] addr,
                      input logic [7:0] data, input logic [15:0] pdata);
    i_reset = rst; i_rd = rd; i_wr = wr; i_addr_rd = ard; i_addr_wr = awr;
    i_pair_ld = pld; i_addr = addr; i_data = data; i_pair_data = pdata;
    #1;
    obs_data = o_data;
    obs_oe   = o_data_oe;
    obs_bus  = o_addr_bus;
    check("strobe_known", 32'($isunknown({i_reset, i_rd, i_wr, i_addr_rd, i_addr_wr, i_pair_ld})), 32'd0);
    if (m_valid) begin
      check("o_data", obs_data, i_rd ? m_byte(i_addr) : 8'h00);
      check("o_data_oe", obs_oe, i_rd);
      check("o_addr_bus", obs_bus, i_addr_rd ? m_pairv(i_addr) : m_latch);
    end
    @(posedge i_clk);
    model_update();
    @(negedge i_clk);
  endtask

  task automatic idle();                                   step(0, 0, 0, 0, 0, 0, 3'd0, 8'h00, 16'h0000); endtask
  task automatic rd8(input logic [2:0] a);                 step(0, 1, 0, 0, 0, 0, a, 8'h00, 16'h0000);    endtask
  task automatic wr8(input logic [2:0] a, input logic [7:0] d); step(0, 0, 1, 0, 0, 0, a, d, 16'h0000);   endtask
  task automatic ard(input logic [2:0] a);                 step(0, 0, 0, 1, 0, 0, a, 8'h00, 16'h0000);    endtask
  task automatic awr();                                    step(0, 0, 0, 0, 1, 0, 3'd0, 8'h00, 16'h0000); endtask
  task automatic pld(input logic [2:0] a, input logic [15:0] v); step(0, 0, 0, 0, 0, 1, a, 8'h00, v);     endtask

  initial begin
    // Reset and idle state
    step(1, 0, 0, 0, 0, 0, 3'd0, 8'h00, 16'h0000);
    idle();
    check("idle_bus", obs_bus, 16'h0000);
    check("idle_data", obs_data, 8'h00);
    check("idle_oe", obs_oe, 1'b0);
    ard(3'd4);
    check("sp_reset", obs_bus, 16'hFFFE);

    // Fetch sequence three times
    for (int i = 0; i < 3; i++) begin
      ard(3'd3);
      check("fetch_rd_bus", obs_bus, 16'(i));
      awr();
      check("fetch_wr_bus", obs_bus, 16'(i));
    end
    ard(3'd3);
    check("pc_after_3", obs_bus, 16'h0003);
    ard(3'd0);
    check("bc_unchanged", obs_bus, 16'h0000);

    // LD B,A and the unused index
    wr8(3'd7, 8'h5A);
    rd8(3'd7);
    check("read_a", obs_data, 8'h5A);
    wr8(3'd0, 8'h5A);
    rd8(3'd0);
    check("read_b", obs_data, 8'h5A);
    wr8(3'd6, 8'hFF);
    rd8(3'd6);
    check("read_none", obs_data, 8'h00);
    for (int r = 0; r < 8; r++) rd8(3'(r));

    // Increment wrap, PC and HL
    pld(3'd3, 16'hFFFF);
    ard(3'd3);
    check("pc_ffff", obs_bus, 16'hFFFF);
    awr();
    ard(3'd3);
    check("pc_wrap", obs_bus, 16'h0000);
    pld(3'd2, 16'h12FF);
    ard(3'd2);
    awr();
    rd8(3'd4);
    check("h_carry", obs_data, 8'h13);
    rd8(3'd5);
    check("l_wrap", obs_data, 8'h00);

    // Conflicts between writers
    ard(3'd3);
    step(0, 0, 0, 0, 1, 1, 3'd3, 8'h00, 16'h8000);
    ard(3'd3);
    check("inc_beats_ld", obs_bus, 16'h0001);
    step(0, 0, 1, 0, 0, 1, 3'd0, 8'h77, 16'hABCD);
    rd8(3'd0);
    check("ld_beats_wr_b", obs_data, 8'hAB);
    rd8(3'd1);
    check("ld_beats_wr_c", obs_data, 8'hCD);
    step(0, 0, 1, 0, 0, 1, 3'd1, 8'h77, 16'h1234);
    rd8(3'd1);
    check("wr_c_parallel", obs_data, 8'h77);
    rd8(3'd2);
    check("ld_d_parallel", obs_data, 8'h12);
    rd8(3'd3);
    check("ld_e_parallel", obs_data, 8'h34);

    // Reset mid-fetch
    pld(3'd3, 16'h0040);
    ard(3'd3);
    check("pc_0040", obs_bus, 16'h0040);
    step(1, 0, 0, 0, 1, 0, 3'd0, 8'h00, 16'h0000);
    idle();
    check("rst_mid_bus", obs_bus, 16'h0000);
    awr();
    ard(3'd3);
    check("rst_ptr_pc", obs_bus, 16'h0001);

    // Random strobes against the model
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(99) == 0), ($urandom_range(99) < 40), ($urandom_range(99) < 35),
           ($urandom_range(99) < 35), ($urandom_range(99) < 30), ($urandom_range(99) < 15),
           3'($urandom_range(7)), 8'($urandom), 16'($urandom));
    end
    // Read back every register and pair at the end
    for (int r = 0; r < 8; r++) rd8(3'(r));
    for (int p = 0; p < 8; p++) ard(3'(p));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
